db_edge_tc_gen: RTL and testbench
=================================

Name: db_edge_tc_gen

Overview:
- Per-edge tc-generation stage of the deblocking filter.
- Accepts one 8x8 edge descriptor per transfer: P-side QP, Q-side QP and boundary strength (bs).
- Forms the HEVC tc table index: averaged QP, plus slice tc offset, clipped, with a bs=2 adjustment.
- Looks up tc and hands {tc, bs, filter enable, edge index} to the luma/chroma edge filter over a valid/ready pipeline with stall support.

Parameters:
- EDGE_CNT_W, 8, width of per-LCU edge index counter (wraps modulo 2^EDGE_CNT_W).
- QP_MAX, 51, upper clip bound for the offset-adjusted QP before the bs adjustment.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lcu_start_i  in  1  one-cycle pulse; clears the edge counter
- tc_offset_div2_i  in  4  signed slice tc offset/2 (range -6..6); quasi-static per slice
- edge_valid_i  in  1  input descriptor valid
- edge_ready_o  out  1  stage can accept a descriptor
- qp_p_i  in  6  P-side luma QP (0..51)
- qp_q_i  in  6  Q-side luma QP (0..51)
- bs_i  in  2  boundary strength 0..2 (3 treated as 2)
- tc_valid_o  out  1  output valid
- tc_ready_i  in  1  downstream accepts
- tc_o  out  5  tc value
- bs_o  out  2  registered bs
- filter_en_o  out  1  1 when bs != 0
- edge_idx_o  out  EDGE_CNT_W  index of this edge within the current LCU

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all valids 0; edge_ready_o=1; tc_o, bs_o, filter_en_o and edge_idx_o all 0; edge counter 0.
- Reset asserted mid-operation drops in-flight descriptors; no output is produced for them.
- Pipeline: two register stages, S1 and S2. Latency is 2 cycles from input handshake to tc_valid_o when there is no stall.
- Transfer rule: a transfer occurs when valid&&ready. Full throughput is one edge per cycle.
- Stall propagation:
  - S2 advances when !s2_valid || tc_ready_i.
  - S1 advances when !s1_valid || S2 advances.
  - edge_ready_o = S1 advance condition. It is combinational from tc_ready_i, with no combinational path from edge_valid_i.
- S1 registers:
  - qp_avg = (qp_p + qp_q + 1) >> 1, 7-bit intermediate sum.
  - bs, with bs=3 mapped to 2.
  - edge_idx = current counter value.
- S2 computes:
  - qp_idx = qp_avg + 2*sign-extended offset, in a signed 8-bit intermediate.
  - Clip qp_idx to [0, QP_MAX].
  - lut_in = qp_idx + (bs==2 ? 2 : 0), maximum 53.
  - tc = LUT(lut_in) when bs!=0; tc=0 when bs==0.
  - filter_en = (bs!=0).
- Output registers hold their value while tc_valid_o && !tc_ready_i. Data must not change until accepted.
- Edge counter:
  - Increments on each input handshake.
  - lcu_start_i zeroes it.
  - If lcu_start_i coincides with a handshake, the accepted edge gets index 0 and the counter becomes 1.
  - Wraps from 2^EDGE_CNT_W-1 to 0 silently.
- tc_offset_div2_i is sampled in S2. The upstream stage only changes it when the pipeline is empty.
- LUT contents (index: tc):
  - 0-17: 0
  - 18-26: 1
  - 27-30: 2
  - 31-34: 3
  - 35-37: 4
  - 38-39: 5
  - 40-41: 6
  - 42: 7, 43: 8, 44: 9, 45: 10, 46: 11, 47: 13, 48: 14
  - 49: 16, 50: 18, 51: 20, 52: 22, 53: 24
  - >53: 0

Decomposition:
- Shared db package holds:
  - QP_MAX, TC_W=5, BS_W=2.
  - Bs encoding constants: BS_NONE=0, BS_INTER=1, BS_INTRA=2.
  - Offset range limits.
- One sub-module: the team's combinational tc table db_lut_tc (qp_i, mb_type_i, tc_o).
  - Instantiated in S2 with qp_i=clipped qp_idx and mb_type_i=(bs==2).
  - Its internal +2 supplies the bs adjustment.
- Handshake and stall logic stay in db_edge_tc_gen.

Test Plan:
- qp_p=37, qp_q=37, bs=1, offset 0, tc_ready_i=1 -> 2 cycles later tc_o=4, filter_en_o=1, edge_idx_o=0. Same with bs=2 -> tc_o=5.
- qp_p=30, qp_q=31 (avg 31), bs=2, offset 0 -> tc_o=3. qp 45/45, bs=2, offset +6 -> idx clipped 51, lut_in 53 -> tc_o=24. qp 20/20, offset -6 -> idx 8 -> tc_o=0.
- bs=0, qp 51/51 -> tc_o=0, filter_en_o=0, bs_o=0. bs=3 -> treated as 2 (bs_o=2).
- Back-to-back stream of 10 edges with tc_ready_i low for cycles 3-6 -> edge_ready_o drops once both stages are full; no loss or duplication; outputs held stable while stalled; edge_idx_o sequence 0..9.
- lcu_start_i pulsed together with the 5th handshake -> that edge gets edge_idx_o=0 and the next edge gets 1. 256 consecutive edges -> index wraps 255->0.
- rst_n asserted asynchronously while both stages are valid -> tc_valid_o=0 immediately, edge_ready_o=1, counter=0; after release, the first new edge emerges with correct tc and index 0.

Source files
------------

// File: rtl/db_edge_tc_gen_pkg.sv
// -----------------------------------------------------------------------------
// db_edge_tc_gen_pkg
// Shared deblocking-filter definitions: QP/tc widths, the QP clip bound,
// boundary-strength encodings, slice tc offset limits and a bs normaliser.
// No ports (package).
// -----------------------------------------------------------------------------
package db_edge_tc_gen_pkg;

    localparam int QP_MAX     = 51;   // upper clip bound of the tc table index
    localparam int QP_W       = 6;    // luma QP width (0..51, also table index)
    localparam int TC_W       = 5;    // tc value width (max 24)
    localparam int BS_W       = 2;    // boundary strength width
    localparam int LUT_IN_MAX = 53;   // largest index the tc table can see

    localparam logic [BS_W-1:0] BS_NONE  = 2'd0;
    localparam logic [BS_W-1:0] BS_INTER = 2'd1;
    localparam logic [BS_W-1:0] BS_INTRA = 2'd2;

    // Legal range of the signed slice tc offset (divided by two).
    localparam int TC_OFFSET_DIV2_MIN = -6;
    localparam int TC_OFFSET_DIV2_MAX = 6;

    // bs=3 is not a legal strength; the filter treats it as intra (2).
    function automatic logic [BS_W-1:0] bs_norm(input logic [BS_W-1:0] bs);
        return (bs == 2'd3) ? BS_INTRA : bs;
    endfunction

endpackage

// File: rtl/db_edge_tc_gen_lut_tc.sv
// -----------------------------------------------------------------------------
// db_lut_tc
// Combinational HEVC tc table. The intra flag adds 2 to the index before the
// lookup, which is how the bs=2 adjustment is applied.
// Ports:
//   qp_i       in  QP_W  clipped table index (0..QP_MAX)
//   mb_type_i  in  1     1 for intra-strength edges (+2 on the index)
//   tc_o       out TC_W  tc value
// -----------------------------------------------------------------------------
module db_lut_tc
    import db_edge_tc_gen_pkg::*;
(
    input  logic [QP_W-1:0] qp_i,
    input  logic            mb_type_i,
    output logic [TC_W-1:0] tc_o
);

    logic [QP_W-1:0] idx;

    always_comb begin
        idx  = qp_i + {{(QP_W-2){1'b0}}, mb_type_i, 1'b0};
        tc_o = '0;
        if (idx <= QP_W'(17)) begin
            tc_o = TC_W'(0);
        end else if (idx <= QP_W'(26)) begin
            tc_o = TC_W'(1);
        end else if (idx <= QP_W'(30)) begin
            tc_o = TC_W'(2);
        end else if (idx <= QP_W'(34)) begin
            tc_o = TC_W'(3);
        end else if (idx <= QP_W'(37)) begin
            tc_o = TC_W'(4);
        end else if (idx <= QP_W'(39)) begin
            tc_o = TC_W'(5);
        end else if (idx <= QP_W'(41)) begin
            tc_o = TC_W'(6);
        end else begin
            case (idx)
                6'd42:   tc_o = TC_W'(7);
                6'd43:   tc_o = TC_W'(8);
                6'd44:   tc_o = TC_W'(9);
                6'd45:   tc_o = TC_W'(10);
                6'd46:   tc_o = TC_W'(11);
                6'd47:   tc_o = TC_W'(13);
                6'd48:   tc_o = TC_W'(14);
                6'd49:   tc_o = TC_W'(16);
                6'd50:   tc_o = TC_W'(18);
                6'd51:   tc_o = TC_W'(20);
                6'd52:   tc_o = TC_W'(22);
                6'd53:   tc_o = TC_W'(24);
                default: tc_o = TC_W'(0);   // beyond LUT_IN_MAX
            endcase
        end
    end

endmodule

// File: rtl/db_edge_tc_gen.sv
// -----------------------------------------------------------------------------
// db_edge_tc_gen
// Per-edge tc generation for the deblocking filter. Two-stage valid/ready
// pipeline: S1 averages the P/Q QPs, normalises bs and tags the edge index;
// S2 applies the slice tc offset, clips, looks up tc and holds the result
// until the edge filter accepts it.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   lcu_start_i         pulse: restart edge numbering for a new LCU
//   tc_offset_div2_i    signed slice tc offset / 2 (sampled in S2)
//   edge_valid_i/edge_ready_o, qp_p_i, qp_q_i, bs_i   input descriptor
//   tc_valid_o/tc_ready_i, tc_o, bs_o, filter_en_o, edge_idx_o   result
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer holds data stable while valid && !ready; edge_ready_o depends only
// on pipeline occupancy and tc_ready_i, never on edge_valid_i.
// -----------------------------------------------------------------------------
module db_edge_tc_gen
    import db_edge_tc_gen_pkg::QP_W, db_edge_tc_gen_pkg::TC_W,
           db_edge_tc_gen_pkg::BS_W, db_edge_tc_gen_pkg::BS_NONE,
           db_edge_tc_gen_pkg::BS_INTRA, db_edge_tc_gen_pkg::bs_norm;
#(
    parameter int EDGE_CNT_W = 8,
    parameter int QP_MAX     = db_edge_tc_gen_pkg::QP_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lcu_start_i,
    input  logic [3:0]            tc_offset_div2_i,
    input  logic                  edge_valid_i,
    output logic                  edge_ready_o,
    input  logic [QP_W-1:0]       qp_p_i,
    input  logic [QP_W-1:0]       qp_q_i,
    input  logic [BS_W-1:0]       bs_i,
    output logic                  tc_valid_o,
    input  logic                  tc_ready_i,
    output logic [TC_W-1:0]       tc_o,
    output logic [BS_W-1:0]       bs_o,
    output logic                  filter_en_o,
    output logic [EDGE_CNT_W-1:0] edge_idx_o
);

    localparam logic signed [7:0] QP_MAX_S = 8'(QP_MAX);
    localparam logic [QP_W-1:0]   QP_MAX_U = QP_W'(QP_MAX);

    // ---------------------------------------------------------------- state
    logic                  s1_valid_q;
    logic [QP_W-1:0]       s1_qp_avg_q, s1_qp_avg_d;
    logic [BS_W-1:0]       s1_bs_q, s1_bs_d;
    logic [EDGE_CNT_W-1:0] s1_idx_q, s1_idx_d;

    logic                  s2_valid_q;
    logic [TC_W-1:0]       s2_tc_q, s2_tc_d;
    logic [BS_W-1:0]       s2_bs_q;
    logic                  s2_fen_q, s2_fen_d;
    logic [EDGE_CNT_W-1:0] s2_idx_q;

    logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;

    // ---------------------------------------------------------- handshakes
    logic s1_adv, s2_adv, in_hs;

    assign s2_adv       = !s2_valid_q || tc_ready_i;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign edge_ready_o = s1_adv;
    assign in_hs        = edge_valid_i && s1_adv;

    // ------------------------------------------------------ S1 next state
    logic [QP_W:0] qp_sum;

    always_comb begin
        qp_sum      = {1'b0, qp_p_i} + {1'b0, qp_q_i} + {{QP_W{1'b0}}, 1'b1};
        s1_qp_avg_d = qp_sum[QP_W:1];
        s1_bs_d     = bs_norm(bs_i);
        // A restart coinciding with an accepted edge numbers that edge 0.
        s1_idx_d    = lcu_start_i ? '0 : cnt_q;
        cnt_d       = cnt_q;
        if (in_hs) begin
            cnt_d = s1_idx_d + 1'b1;
        end else if (lcu_start_i) begin
            cnt_d = '0;
        end
    end

    // ------------------------------------------------------ S2 next state
    logic signed [7:0] off_x2;
    logic signed [7:0] qp_idx;
    logic [QP_W-1:0]   qp_clip;
    logic [TC_W-1:0]   lut_tc;

    always_comb begin
        off_x2 = {{3{tc_offset_div2_i[3]}}, tc_offset_div2_i, 1'b0};
        qp_idx = $signed({2'b00, s1_qp_avg_q}) + off_x2;
        if (qp_idx < 8'sd0) begin
            qp_clip = '0;
        end else if (qp_idx > QP_MAX_S) begin
            qp_clip = QP_MAX_U;
        end else begin
            qp_clip = qp_idx[QP_W-1:0];
        end
        s2_fen_d = (s1_bs_q != BS_NONE);
        s2_tc_d  = s2_fen_d ? lut_tc : '0;
    end

    db_lut_tc u_lut_tc (
        .qp_i      (qp_clip),
        .mb_type_i (s1_bs_q == BS_INTRA),
        .tc_o      (lut_tc)
    );

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_qp_avg_q <= '0;
            s1_bs_q     <= '0;
            s1_idx_q    <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= edge_valid_i;
            if (in_hs) begin
                s1_qp_avg_q <= s1_qp_avg_d;
                s1_bs_q     <= s1_bs_d;
                s1_idx_q    <= s1_idx_d;
            end
        end
    end

    // Output registers only move when the stage advances, so data is held
    // while the downstream filter stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_tc_q    <= '0;
            s2_bs_q    <= '0;
            s2_fen_q   <= 1'b0;
            s2_idx_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_tc_q  <= s2_tc_d;
                s2_bs_q  <= s1_bs_q;
                s2_fen_q <= s2_fen_d;
                s2_idx_q <= s1_idx_q;
            end
        end
    end

    assign tc_valid_o  = s2_valid_q;
    assign tc_o        = s2_tc_q;
    assign bs_o        = s2_bs_q;
    assign filter_en_o = s2_fen_q;
    assign edge_idx_o  = s2_idx_q;

endmodule

// File: tb/tb_db_edge_tc_gen.sv
module tb_db_edge_tc_gen;

  logic       clk;
  logic       rst_n;
  logic       lcu_start_i;
  logic [3:0] tc_offset_div2_i;
  logic       edge_valid_i;
  logic       edge_ready_o;
  logic [5:0] qp_p_i;
  logic [5:0] qp_q_i;
  logic [1:0] bs_i;
  logic       tc_valid_o;
  logic       tc_ready_i;
  logic [4:0] tc_o;
  logic [1:0] bs_o;
  logic       filter_en_o;
  logic [7:0] edge_idx_o;

  int checks = 0;
  int errors = 0;

  // expected {tc, edge_idx}
  logic [12:0] exp_q[$];

  typedef struct {
    int qp_p; int qp_q; int bs; int off;
    int tc; int bso; int fen;
  } vec_t;

  db_edge_tc_gen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lcu_start_i      (lcu_start_i),
    .tc_offset_div2_i (tc_offset_div2_i),
    .edge_valid_i     (edge_valid_i),
    .edge_ready_o     (edge_ready_o),
    .qp_p_i           (qp_p_i),
    .qp_q_i           (qp_q_i),
    .bs_i             (bs_i),
    .tc_valid_o       (tc_valid_o),
    .tc_ready_i       (tc_ready_i),
    .tc_o             (tc_o),
    .bs_o             (bs_o),
    .filter_en_o      (filter_en_o),
    .edge_idx_o       (edge_idx_o)
  );

  // ---------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------- driver tasks
  task automatic drive_edge(input int qp_p, input int qp_q, input int bs,
                            input int off, input logic lcu);
    int n;
    @(negedge clk);
    qp_p_i           = 6'(qp_p);
    qp_q_i           = 6'(qp_q);
    bs_i             = 2'(bs);
    tc_offset_div2_i = 4'(off);
    lcu_start_i      = lcu;
    edge_valid_i     = 1'b1;
    n = 0;
    while (!edge_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    edge_valid_i = 1'b0;
    lcu_start_i  = 1'b0;
  endtask

  // Waits (bounded) for tc_valid_o; lat counts negedges after the handshake.
  task automatic wait_out(output logic got, output int lat,
                          output logic [4:0] tc, output logic [1:0] bs,
                          output logic fen, output logic [7:0] idx);
    got = 1'b0; lat = 0; tc = '0; bs = '0; fen = 1'b0; idx = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (tc_valid_o) begin
        got = 1'b1; tc = tc_o; bs = bs_o; fen = filter_en_o; idx = edge_idx_o;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0; lcu_start_i = 1'b0; tc_offset_div2_i = '0; edge_valid_i = 1'b0;
    qp_p_i = '0; qp_q_i = '0; bs_i = '0; tc_ready_i = 1'b1;
    #12;
    checks++;
    if (tc_valid_o !== 1'b0 || edge_ready_o !== 1'b1 || tc_o !== 5'd0 ||
        bs_o !== 2'd0 || filter_en_o !== 1'b0 || edge_idx_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: valid=%b ready=%b tc=%0d bs=%0d fen=%b idx=%0d, want 0 1 0 0 0 0",
               tc_valid_o, edge_ready_o, tc_o, bs_o, filter_en_o, edge_idx_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic got; int lat; logic [4:0] tc; logic [1:0] bs; logic fen; logic [7:0] idx;
    drive_edge(37, 37, 1, 0, 1'b0);
    wait_out(got, lat, tc, bs, fen, idx);
    checks++;
    if (!got || lat != 2) begin
      errors++;
      $display("FAIL basic_latency: got=%b lat=%0d, want got=1 lat=2", got, lat);
    end
    checks++;
    if (tc !== 5'd4 || fen !== 1'b1 || bs !== 2'd1 || idx !== 8'd0) begin
      errors++;
      $display("FAIL basic_bs1: tc=%0d fen=%b bs=%0d idx=%0d, want 4 1 1 0", tc, fen, bs, idx);
    end
    drive_edge(37, 37, 2, 0, 1'b0);
    wait_out(got, lat, tc, bs, fen, idx);
    checks++;
    if (!got || tc !== 5'd5 || bs !== 2'd2 || idx !== 8'd1) begin
      errors++;
      $display("FAIL basic_bs2: got=%b tc=%0d bs=%0d idx=%0d, want 1 5 2 1", got, tc, bs, idx);
    end
  endtask

  task automatic test_tc_vectors();
    vec_t vecs[12];
    logic got; int lat; logic [4:0] tc; logic [1:0] bs; logic fen; logic [7:0] idx;
    vecs[0]  = '{37, 37, 1,  0,  4, 1, 1};
    vecs[1]  = '{37, 37, 2,  0,  5, 2, 1};
    vecs[2]  = '{30, 31, 2,  0,  3, 2, 1};
    vecs[3]  = '{45, 45, 2,  6, 24, 2, 1};  // 57 clipped to 51, +2 -> 53
    vecs[4]  = '{20, 20, 1, -6,  0, 1, 1};  // idx 8
    vecs[5]  = '{51, 51, 0,  0,  0, 0, 0};  // bs 0 disables filter
    vecs[6]  = '{37, 37, 3,  0,  5, 2, 1};  // bs 3 behaves as 2
    vecs[7]  = '{51, 50, 1,  0, 20, 1, 1};  // avg rounds up to 51
    vecs[8]  = '{40, 41, 1, -1,  5, 1, 1};  // 41-2 = 39
    vecs[9]  = '{ 0,  1, 2, -6,  0, 2, 1};  // negative clipped to 0, +2
    vecs[10] = '{45, 45, 1,  6, 20, 1, 1};  // clip to 51, no +2
    vecs[11] = '{18, 17, 1,  0,  1, 1, 1};  // (35+1)>>1 = 18
    for (int v = 0; v < 12; v++) begin
      drive_edge(vecs[v].qp_p, vecs[v].qp_q, vecs[v].bs, vecs[v].off, 1'b1);
      wait_out(got, lat, tc, bs, fen, idx);
      checks++;
      if (!got || tc !== 5'(vecs[v].tc) || bs !== 2'(vecs[v].bso) ||
          fen !== 1'(vecs[v].fen) || idx !== 8'd0) begin
        errors++;
        $display("FAIL tc_vec%0d: got=%b tc=%0d bs=%0d fen=%b idx=%0d, want tc=%0d bs=%0d fen=%0d idx=0",
                 v, got, tc, bs, fen, idx, vecs[v].tc, vecs[v].bso, vecs[v].fen);
      end
    end
    tc_offset_div2_i = '0;
  endtask

  task automatic test_back_to_back();
    int exp_tc[10];
    int next_i, recv, c;
    logic saw_bp, hold_pending, in_hs;
    logic [4:0] h_tc; logic [1:0] h_bs; logic h_fen; logic [7:0] h_idx;
    logic [12:0] e;
    exp_tc = '{2, 3, 3, 3, 3, 4, 4, 4, 5, 5};   // indices 30..39, bs 1
    for (int i = 0; i < 10; i++) exp_q.push_back({5'(exp_tc[i]), 8'(i)});
    next_i = 0; recv = 0; c = 0; saw_bp = 1'b0; hold_pending = 1'b0;
    h_tc = '0; h_bs = '0; h_fen = 1'b0; h_idx = '0;
    while (recv < 10 && c < 80) begin
      @(negedge clk);
      tc_ready_i   = !(c >= 3 && c <= 6);
      edge_valid_i = (next_i < 10);
      qp_p_i       = 6'(30 + next_i);
      qp_q_i       = 6'(30 + next_i);
      bs_i         = 2'd1;
      lcu_start_i  = (next_i == 0);
      #1;
      if (edge_valid_i && !edge_ready_o) saw_bp = 1'b1;
      if (hold_pending) begin
        checks++;
        if (!tc_valid_o || tc_o !== h_tc || bs_o !== h_bs ||
            filter_en_o !== h_fen || edge_idx_o !== h_idx) begin
          errors++;
          $display("FAIL b2b_hold: valid=%b tc=%0d idx=%0d, want held valid=1 tc=%0d idx=%0d",
                   tc_valid_o, tc_o, edge_idx_o, h_tc, h_idx);
        end
      end
      if (tc_valid_o && tc_ready_i) begin
        hold_pending = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected output tc=%0d idx=%0d", tc_o, edge_idx_o);
        end else begin
          e = exp_q.pop_front();
          if (tc_o !== e[12:8] || edge_idx_o !== e[7:0] || filter_en_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_data: tc=%0d idx=%0d fen=%b, want tc=%0d idx=%0d fen=1",
                     tc_o, edge_idx_o, filter_en_o, e[12:8], e[7:0]);
          end
        end
        recv++;
      end else if (tc_valid_o) begin
        hold_pending = 1'b1;
        h_tc = tc_o; h_bs = bs_o; h_fen = filter_en_o; h_idx = edge_idx_o;
      end else begin
        hold_pending = 1'b0;
      end
      in_hs = edge_valid_i && edge_ready_o;
      @(posedge clk);
      if (in_hs) next_i++;
      c++;
    end
    #1;
    edge_valid_i = 1'b0; lcu_start_i = 1'b0; tc_ready_i = 1'b1;
    checks++;
    if (recv != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: received=%0d left=%0d, want 10 0", recv, exp_q.size());
    end
    checks++;
    if (!saw_bp) begin
      errors++;
      $display("FAIL b2b_backpressure: edge_ready_o never dropped, want drop while stalled");
    end
    exp_q.delete();
  endtask

  // Always-ready stream; restart pulses at the listed positions.
  task automatic test_lcu_restart();
    int n_bad;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (!tc_valid_o || edge_idx_o !== 8'((i - 2) % 4) || tc_o !== 5'd4) begin
          errors++;
          $display("FAIL lcu_idx%0d: valid=%b idx=%0d tc=%0d, want 1 %0d 4",
                   i - 2, tc_valid_o, edge_idx_o, tc_o, (i - 2) % 4);
        end
      end
      edge_valid_i = (i < 8);
      qp_p_i = 6'd37; qp_q_i = 6'd37; bs_i = 2'd1;
      lcu_start_i = (i == 0 || i == 4);
    end
    edge_valid_i = 1'b0; lcu_start_i = 1'b0;
    // 258 edges: numbering wraps 255 -> 0
    n_bad = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (!tc_valid_o || edge_idx_o !== 8'((i - 2) % 256)) begin
          errors++;
          n_bad++;
          if (n_bad < 5)
            $display("FAIL wrap_idx%0d: valid=%b idx=%0d, want 1 %0d",
                     i - 2, tc_valid_o, edge_idx_o, (i - 2) % 256);
        end
      end
      edge_valid_i = (i < 258);
      lcu_start_i  = (i == 0);
    end
    edge_valid_i = 1'b0; lcu_start_i = 1'b0;
  endtask

  task automatic test_async_reset();
    logic got; int lat; logic [4:0] tc; logic [1:0] bs; logic fen; logic [7:0] idx;
    logic leak;
    tc_ready_i = 1'b0;
    drive_edge(45, 45, 2, 0, 1'b0);
    drive_edge(45, 45, 2, 0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (tc_valid_o !== 1'b1 || edge_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_precond: valid=%b ready=%b, want 1 0", tc_valid_o, edge_ready_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tc_valid_o !== 1'b0 || edge_ready_o !== 1'b1 || edge_idx_o !== 8'd0 || tc_o !== 5'd0) begin
      errors++;
      $display("FAIL rst_async: valid=%b ready=%b idx=%0d tc=%0d, want 0 1 0 0",
               tc_valid_o, edge_ready_o, edge_idx_o, tc_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tc_ready_i = 1'b1;
    leak = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (tc_valid_o) leak = 1'b1;
    end
    checks++;
    if (leak) begin
      errors++;
      $display("FAIL rst_drop: tc_valid_o seen after reset, want no output for dropped edges");
    end
    drive_edge(37, 37, 2, 0, 1'b0);
    wait_out(got, lat, tc, bs, fen, idx);
    checks++;
    if (!got || tc !== 5'd5 || idx !== 8'd0) begin
      errors++;
      $display("FAIL rst_first_edge: got=%b tc=%0d idx=%0d, want 1 5 0", got, tc, idx);
    end
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_basic();
    test_tc_vectors();
    test_back_to_back();
    test_lcu_restart();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
